// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8-bit LSB-first UART receiver with a one-entry holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse; 8N1 otherwise.
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       rx,
  output logic [7:0] recv,
  output logic       recv_avail,
  input  logic       recv_ack,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = $clog2(DIV) + 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] D_END = DW'(DIV - 1);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ONE = SW'(1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DIV < 1) begin : g_bad_cfg
    $error("uart_rx: OVERSAMPLE must be even and >= 8, DIV >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT
  } state_t;

  logic          rx_meta_q;
  logic          rx_s_q;
  logic [DW-1:0] div_q;
  logic          tick;

  state_t        state_q;
  logic [SW-1:0] scnt_q;
  logic [SW-1:0] scnt_nx;
  logic [2:0]    bcnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    recv_q;
  logic          recv_avail_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          par_ok;
  logic          bit_end;
  logic          take;

  // Synchronizer resets high so reset release never looks like a start edge
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      div_q <= '0;
    end else if (div_q == D_END) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + D_ONE;
    end
  end

  assign tick    = (div_q == D_END);
  assign bit_end = (scnt_q == S_END);
  assign scnt_nx = bit_end ? '0 : scnt_q + S_ONE;
  assign take    = !recv_avail_q || recv_ack;

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic parity_err_q;

  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      recv_q       <= '0;
      recv_avail_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (recv_avail_q && recv_ack) begin
        recv_avail_q <= 1'b0;
      end
      if (tick) begin
        unique case (state_q)
          S_IDLE: begin
            if (!rx_s_q) begin
              scnt_q  <= '0;
              state_q <= S_START;
            end
          end
          S_START: begin
            if (scnt_q == S_MID) begin
              if (!rx_s_q) begin
                scnt_q  <= '0;
                bcnt_q  <= '0;
                state_q <= S_DATA;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              scnt_q <= scnt_q + S_ONE;
            end
          end
          S_DATA: begin
            scnt_q <= scnt_nx;
            if (bit_end) begin
              shift_q <= {rx_s_q, shift_q[7:1]};
              bcnt_q  <= bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            scnt_q <= scnt_nx;
            if (bit_end) begin
              par_q   <= rx_s_q;
              state_q <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            scnt_q <= scnt_nx;
            if (bit_end) begin
              state_q <= rx_s_q ? S_IDLE : S_WAIT;
              if (!rx_s_q) begin
                frame_err_q <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              if (!par_ok) begin
                parity_err_q <= 1'b1;
              end
`endif
              if (rx_s_q && par_ok) begin
                if (take) begin
                  recv_q       <= shift_q;
                  recv_avail_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end
            end
          end
          // A held-low line (break) must go high before a new start is armed
          S_WAIT: begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign recv       = recv_q;
  assign recv_avail = recv_avail_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx with a queue scoreboard and negedge monitor.
// Build with UART_RX_PARITY_EN defined to also cover the 8E1 cases.
module tb_uart_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int OS       = 16;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       rx = 1'b1;
  logic       recv_ack = 1'b0;
  logic [7:0] recv;
  logic       recv_avail;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .rx        (rx),
    .recv      (recv),
    .recv_avail(recv_avail),
    .recv_ack  (recv_ack),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {EV_BYTE, EV_FERR, EV_OVR, EV_PERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  lat = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected event: got kind %0d data 0x%0h, want none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_BYTE && e.data !== d)) begin
        miscompares++;
        $display("FAIL event: got kind %0d data 0x%0h, want kind %0d data 0x%0h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  logic prev_avail = 1'b0;
  logic prev_ack = 1'b0;

  // Monitor: a byte is presented when avail rises or is refilled in an ack cycle
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_avail = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (recv_avail && (!prev_avail || prev_ack)) got(EV_BYTE, recv);
      if (frame_err) got(EV_FERR, 8'h00);
      if (overrun) got(EV_OVR, 8'h00);
`ifdef UART_RX_PARITY_EN
      if (parity_err) got(EV_PERR, 8'h00);
`endif
      prev_avail = recv_avail;
      prev_ack   = recv_ack;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic ack_byte(input string name);
    int n;
    n = 0;
    while (!recv_avail && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " avail before ack"}, int'(recv_avail), 1);
    recv_ack = 1'b1;
    @(posedge clk);
    #1;
    recv_ack = 1'b0;
    check({name, " avail cleared by ack"}, int'(recv_avail), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    check("reset recv", int'(recv), 'h00);
    check("reset avail", int'(recv_avail), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    aresetn = 1'b1;
    idle(5);

    // Plain byte with latency window from the falling edge
    b = 8'hA5;
    expect_ev(EV_BYTE, b);
    fork
      send(b, 1'b1, ^b);
      begin
        lat = 0;
        while (!recv_avail && lat < 300) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    vectors++;
    if (lat < 152 || lat > 156) begin
      miscompares++;
      $display("FAIL A5 latency: got %0d clocks, want 152..156", lat);
    end
    check("A5 recv", int'(recv), 'hA5);
    ack_byte("A5");
    idle(4);

    // Short low glitch must not start a frame
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("glitch avail", int'(recv_avail), 0);
    b = 8'h3C;
    expect_ev(EV_BYTE, b);
    send(b, 1'b1, ^b);
    idle(2);
    ack_byte("3C");

    // Bad stop bit followed by a long break
    b = 8'h55;
    expect_ev(EV_FERR, 8'h00);
    send(b, 1'b0, ^b);
    repeat (40) @(posedge clk);
    #1;
    idle(20);
    check("ferr avail", int'(recv_avail), 0);
    b = 8'h81;
    expect_ev(EV_BYTE, b);
    send(b, 1'b1, ^b);
    idle(2);
    ack_byte("81");

    // Overrun: second byte dropped while the first is held
    b = 8'h11;
    expect_ev(EV_BYTE, b);
    send(b, 1'b1, ^b);
    idle(4);
    b = 8'h22;
    expect_ev(EV_OVR, 8'h00);
    send(b, 1'b1, ^b);
    idle(4);
    check("overrun keeps recv", int'(recv), 'h11);
    ack_byte("overrun");

    // Ack in the deliver cycle accepts the new byte without overrun
    b = 8'h11;
    expect_ev(EV_BYTE, b);
    send(b, 1'b1, ^b);
    idle(4);
    b = 8'h22;
    expect_ev(EV_BYTE, b);
    fork
      send(b, 1'b1, ^b);
      begin
        repeat (154) @(posedge clk);
        #1;
        recv_ack = 1'b1;
        @(posedge clk);
        #1;
        recv_ack = 1'b0;
      end
    join
    check("same-cycle ack recv", int'(recv), 'h22);
    ack_byte("22");

    // Reset in the middle of data bit 3, with a byte held
    b = 8'h77;
    expect_ev(EV_BYTE, b);
    send(b, 1'b1, ^b);
    idle(4);
    b = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx = b[3];
    repeat (6) @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    check("midreset recv", int'(recv), 'h00);
    check("midreset avail", int'(recv_avail), 0);
    check("midreset frame_err", int'(frame_err), 0);
    check("midreset overrun", int'(overrun), 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    aresetn = 1'b1;
    idle(10);
    b = 8'h5A;
    expect_ev(EV_BYTE, b);
    send(b, 1'b1, ^b);
    idle(2);
    check("post-reset recv", int'(recv), 'h5A);
    ack_byte("5A");

`ifdef UART_RX_PARITY_EN
    b = 8'h07;
    expect_ev(EV_BYTE, b);
    send(b, 1'b1, 1'b1);
    idle(2);
    ack_byte("parity ok");
    expect_ev(EV_PERR, 8'h00);
    send(b, 1'b1, 1'b0);
    idle(20);
    check("parity bad avail", int'(recv_avail), 0);
`endif

    idle(50);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
